// File: rtl/int_bit_manip_ctrl.sv
// Command sequencer for the 64-bit bit-manipulation datapath: expands range commands into per-bit operations.
// Optional statistics counters are compiled in with the INT_BIT_MANIP_CTRL_STATS_EN macro.
module int_bit_manip_ctrl #(
  parameter int BM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [63:0] cmd_opa,
  input  logic [5:0]  cmd_lo,
  input  logic [5:0]  cmd_hi,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        res_err,
  output logic        bm_issue,
  output logic [2:0]  bm_operation,
  output logic [63:0] bm_opa,
  output logic [63:0] bm_opb,
  input  logic [63:0] bm_out
`ifdef INT_BIT_MANIP_CTRL_STATS_EN
  ,
  output logic [31:0] stat_cmds,
  output logic [31:0] stat_busy
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_SET  = 3'b001;
  localparam logic [2:0] OP_CNT  = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b011;

  localparam logic [2:0] LAST_WAIT = 3'(BM_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [63:0] w_q, w_d;
  logic [6:0]  c_q, c_d;
  logic [5:0]  i_q, i_d;
  logic [5:0]  hi_q, hi_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  wait_q, wait_d;
  logic [63:0] res_data_q, res_data_d;
  logic        res_err_q, res_err_d;
  logic        res_valid_q, res_valid_d;
  logic        bm_issue_q, bm_issue_d;
  logic [2:0]  bm_operation_q, bm_operation_d;
  logic        cmd_bad_s;

  assign cmd_ready    = (state_q == IDLE) && rst;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_err      = res_err_q;
  assign bm_issue     = bm_issue_q;
  assign bm_operation = bm_operation_q;
  assign bm_opa       = w_q;
  assign bm_opb       = {58'd0, i_q};

  // Illegal opcode, or a reversed range on one of the three range ops (PASS ignores lo/hi).
  assign cmd_bad_s = cmd_op[2] || ((cmd_op != OP_PASS) && (cmd_hi < cmd_lo));

  // Next-state, working-register and result computation.
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    c_d        = c_q;
    i_d        = i_q;
    hi_d       = hi_q;
    op_d       = op_q;
    wait_d     = wait_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          w_d    = cmd_opa;
          c_d    = 7'd0;
          hi_d   = cmd_hi;
          op_d   = cmd_op;
          wait_d = 3'd0;
          if (cmd_op == OP_PASS) begin
            i_d = 6'd0;
          end else begin
            i_d = cmd_lo;
          end
          if (cmd_bad_s) begin
            state_d    = DONE;
            res_data_d = 64'd0;
            res_err_d  = 1'b1;
          end else begin
            state_d    = ISSUE;
            res_data_d = 64'd0;
            res_err_d  = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wait_d  = 3'd0;
      end
      WAIT: begin
        if (wait_q == LAST_WAIT) begin
          wait_d = 3'd0;
          if (op_q == OP_CNT) begin
            c_d = c_q + {6'd0, bm_out[0]};
          end else begin
            w_d = bm_out;
          end
          // I stops at hi, so a range ending at 63 never wraps the index.
          if ((op_q == OP_PASS) || (i_q == hi_q)) begin
            state_d   = DONE;
            res_err_d = 1'b0;
            if (op_q == OP_CNT) begin
              res_data_d = {57'd0, c_d};
            end else begin
              res_data_d = bm_out;
            end
          end else begin
            i_d     = i_q + 6'd1;
            state_d = ISSUE;
          end
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output strobes are registered from the next state so they align with the state register.
  always_comb begin
    res_valid_d    = (state_d == DONE);
    bm_issue_d     = (state_d == ISSUE);
    if (state_d == ISSUE) begin
      bm_operation_d = op_d;
    end else begin
      bm_operation_d = OP_PASS;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      w_q            <= 64'd0;
      c_q            <= 7'd0;
      i_q            <= 6'd0;
      hi_q           <= 6'd0;
      op_q           <= 3'd0;
      wait_q         <= 3'd0;
      res_data_q     <= 64'd0;
      res_err_q      <= 1'b0;
      res_valid_q    <= 1'b0;
      bm_issue_q     <= 1'b0;
      bm_operation_q <= OP_PASS;
    end else begin
      state_q        <= state_d;
      w_q            <= w_d;
      c_q            <= c_d;
      i_q            <= i_d;
      hi_q           <= hi_d;
      op_q           <= op_d;
      wait_q         <= wait_d;
      res_data_q     <= res_data_d;
      res_err_q      <= res_err_d;
      res_valid_q    <= res_valid_d;
      bm_issue_q     <= bm_issue_d;
      bm_operation_q <= bm_operation_d;
    end
  end

`ifdef INT_BIT_MANIP_CTRL_STATS_EN
  logic [31:0] stat_cmds_q, stat_cmds_d;
  logic [31:0] stat_busy_q, stat_busy_d;

  assign stat_cmds = stat_cmds_q;
  assign stat_busy = stat_busy_q;

  // Completed result handshakes (errors included) and non-idle cycles, both wrapping.
  always_comb begin
    stat_cmds_d = stat_cmds_q;
    stat_busy_d = stat_busy_q;
    if (res_valid_q && res_ready) begin
      stat_cmds_d = stat_cmds_q + 32'd1;
    end else begin
      stat_cmds_d = stat_cmds_q;
    end
    if (state_q != IDLE) begin
      stat_busy_d = stat_busy_q + 32'd1;
    end else begin
      stat_busy_d = stat_busy_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_cmds_q <= 32'd0;
      stat_busy_q <= 32'd0;
    end else begin
      stat_cmds_q <= stat_cmds_d;
      stat_busy_q <= stat_busy_d;
    end
  end
`endif

endmodule

// File: tb/tb_int_bit_manip_ctrl.sv
// Directed bench for int_bit_manip_ctrl with a one-cycle-latency datapath model.
module tb_int_bit_manip_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'b000;
  logic [63:0] cmd_opa = 64'd0;
  logic [5:0]  cmd_lo = 6'd0;
  logic [5:0]  cmd_hi = 6'd0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic        res_err;
  logic        bm_issue;
  logic [2:0]  bm_operation;
  logic [63:0] bm_opa;
  logic [63:0] bm_opb;
  logic [63:0] bm_out = 64'd0;
`ifdef INT_BIT_MANIP_CTRL_STATS_EN
  logic [31:0] stat_cmds;
  logic [31:0] stat_busy;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issue_cnt = 0;
  logic [5:0] opb_log[$];
  logic [2:0] op_log[$];

  int_bit_manip_ctrl #(.BM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_opa(cmd_opa), .cmd_lo(cmd_lo), .cmd_hi(cmd_hi),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .bm_issue(bm_issue), .bm_operation(bm_operation), .bm_opa(bm_opa), .bm_opb(bm_opb),
    .bm_out(bm_out)
`ifdef INT_BIT_MANIP_CTRL_STATS_EN
    , .stat_cmds(stat_cmds), .stat_busy(stat_busy)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: result valid only in the cycle after issue, junk otherwise.
  always @(posedge clk) begin
    if (bm_issue) begin
      issue_cnt <= issue_cnt + 1;
      opb_log.push_back(bm_opb[5:0]);
      op_log.push_back(bm_operation);
      case (bm_operation)
        3'b000:  bm_out <= bm_opa & ~(64'd1 << bm_opb[5:0]);
        3'b001:  bm_out <= bm_opa | (64'd1 << bm_opb[5:0]);
        3'b010:  bm_out <= {63'd0, bm_opa[bm_opb[5:0]]};
        default: bm_out <= bm_opa;
      endcase
    end else begin
      bm_out <= 64'hDEAD_BEEF_0BAD_F00D;
    end
  end

  task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [63:0] opa, input logic [5:0] lo,
                         input logic [5:0] hi, input int hold, output logic [63:0] data,
                         output logic err, output int lat, output int n_iss, output int first_idx);
    int t0;
    int base;
    int k;
    @(negedge clk);
    chk64("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_opa = opa; cmd_lo = lo; cmd_hi = hi;
    t0 = cyc; base = issue_cnt; first_idx = opb_log.size();
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (!res_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk64("res_valid_timeout", {63'd0, res_valid}, 64'd1);
    lat = cyc - t0;
    data = res_data;
    err = res_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk64("hold_res_valid", {63'd0, res_valid}, 64'd1);
      chk64("hold_res_data", res_data, data);
      chk64("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk64("res_valid_drop", {63'd0, res_valid}, 64'd0);
    n_iss = issue_cnt - base;
  endtask

  initial begin
    logic [63:0] data;
    logic        err;
    int          lat;
    int          n_iss;
    int          fi;
    logic        seen;

    // Reset for two cycles, release on a falling edge.
    @(negedge clk);
    @(negedge clk);
    chk64("rst_cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
    rst = 1'b1;
    #1;
    chk64("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk64("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk64("rst_res_err", {63'd0, res_err}, 64'd0);
    chk64("rst_res_data", res_data, 64'd0);
    chk64("rst_bm_issue", {63'd0, bm_issue}, 64'd0);
    chk64("rst_bm_operation", {61'd0, bm_operation}, 64'd3);
    chk64("rst_bm_opa", bm_opa, 64'd0);
    chk64("rst_bm_opb", bm_opb, 64'd0);

    // SET bits 4..7 of zero.
    run_cmd(3'b001, 64'd0, 6'd4, 6'd7, 0, data, err, lat, n_iss, fi);
    chk64("set_data", data, 64'h0000_0000_0000_00F0);
    chk64("set_err", {63'd0, err}, 64'd0);
    chk64("set_latency", 64'(lat), 64'd9);
    chk64("set_issues", 64'(n_iss), 64'd4);
    chk64("set_opb0", {58'd0, opb_log[fi]}, 64'd4);
    chk64("set_opb1", {58'd0, opb_log[fi+1]}, 64'd5);
    chk64("set_opb2", {58'd0, opb_log[fi+2]}, 64'd6);
    chk64("set_opb3", {58'd0, opb_log[fi+3]}, 64'd7);
    chk64("set_opcode", {61'd0, op_log[fi]}, 64'd1);

    // CLR the full range of an all-ones word.
    run_cmd(3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 6'd63, 0, data, err, lat, n_iss, fi);
    chk64("clr_data", data, 64'd0);
    chk64("clr_latency", 64'(lat), 64'd129);
    chk64("clr_issues", 64'(n_iss), 64'd64);
    chk64("clr_last_opb", {58'd0, opb_log[fi+63]}, 64'd63);
    chk64("clr_opcode", {61'd0, op_log[fi]}, 64'd0);

    // CNT: bits 0,2,5,7 of A5 plus bit 63 give five.
    run_cmd(3'b010, 64'h8000_0000_0000_00A5, 6'd0, 6'd63, 0, data, err, lat, n_iss, fi);
    chk64("cnt_full_data", data, 64'd5);
    chk64("cnt_full_issues", 64'(n_iss), 64'd64);
    chk64("cnt_opcode", {61'd0, op_log[fi]}, 64'd2);
    run_cmd(3'b010, 64'h8000_0000_0000_00A5, 6'd1, 6'd1, 0, data, err, lat, n_iss, fi);
    chk64("cnt_single_data", data, 64'd0);
    chk64("cnt_single_latency", 64'(lat), 64'd3);
    chk64("cnt_single_issues", 64'(n_iss), 64'd1);

    // Illegal opcode with the result held for three cycles.
    run_cmd(3'b101, 64'h1111_2222_3333_4444, 6'd0, 6'd5, 3, data, err, lat, n_iss, fi);
    chk64("illegal_err", {63'd0, err}, 64'd1);
    chk64("illegal_data", data, 64'd0);
    chk64("illegal_latency", 64'(lat), 64'd1);
    chk64("illegal_issues", 64'(n_iss), 64'd0);

    // Reversed range.
    run_cmd(3'b001, 64'h0F0F, 6'd9, 6'd3, 0, data, err, lat, n_iss, fi);
    chk64("reversed_err", {63'd0, err}, 64'd1);
    chk64("reversed_data", data, 64'd0);
    chk64("reversed_latency", 64'(lat), 64'd1);
    chk64("reversed_issues", 64'(n_iss), 64'd0);

    // Reset during the second WAIT of a SET_RANGE aborts the command.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_opa = 64'd0; cmd_lo = 6'd0; cmd_hi = 6'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk64("abort_in_wait", {63'd0, bm_issue}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk64("abort_cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
    chk64("abort_opa_cleared", bm_opa, 64'd0);
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    chk64("abort_no_result", {63'd0, seen}, 64'd0);

    // PASS ignores lo/hi and issues once with opb=0.
    run_cmd(3'b011, 64'h1234, 6'd5, 6'd2, 0, data, err, lat, n_iss, fi);
    chk64("pass_data", data, 64'h1234);
    chk64("pass_err", {63'd0, err}, 64'd0);
    chk64("pass_latency", 64'(lat), 64'd3);
    chk64("pass_issues", 64'(n_iss), 64'd1);
    chk64("pass_opb", {58'd0, opb_log[fi]}, 64'd0);
    chk64("pass_opcode", {61'd0, op_log[fi]}, 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
